// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, the token-to-control mapping,
// receive alignment states and the per-word decode result.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic {StSearch, StLocked} rx_state_e;

  typedef struct packed {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } tmds_dec_t;

  // Returns {is_ctrl, c1, c0}; any non-token word gives 3'b000.
  function automatic logic [2:0] tmds_ctrl_decode(input logic [9:0] word);
    logic [2:0] res;
    case (word)
      TMDS_CTRL_00: res = 3'b100;
      TMDS_CTRL_01: res = 3'b101;
      TMDS_CTRL_10: res = 3'b110;
      TMDS_CTRL_11: res = 3'b111;
      default:      res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: 10-bit symbol to {de, c1, c0, data}.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word_i,
  output tmds_dec_t  dec_o
);

  logic [2:0] ctrl;
  logic [7:0] q;
  logic [7:0] d;

  always_comb begin
    ctrl = tmds_ctrl_decode(word_i);
    q    = word_i[9] ? ~word_i[7:0] : word_i[7:0];
    d    = '0;
    d[0] = q[0];
    // Bit 8 selects whether the transmitter chained the bits with XOR or XNOR.
    for (int i = 1; i < 8; i++) begin
      d[i] = word_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    dec_o.de   = ~ctrl[2];
    dec_o.c1   = ctrl[1];
    dec_o.c0   = ctrl[0];
    dec_o.data = ctrl[2] ? 8'h00 : d;
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: finds word alignment on blanking token runs, then
// decodes aligned words to pixel data or control bits.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN = 8,
  parameter int unsigned WINDOW   = 4096,
  parameter int unsigned TMR_W    = 13
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds_word,
  output logic [7:0] O_data,
  output logic       O_c0,
  output logic       O_c1,
  output logic       O_de,
  output logic       O_locked,
  output logic [3:0] O_offset,
  output logic       O_slip
);

  localparam int unsigned RunW = $clog2(CTRL_RUN + 1);
  localparam logic [RunW-1:0]  RunMax = RunW'(CTRL_RUN);
  localparam logic [RunW-1:0]  RunPre = RunW'(CTRL_RUN - 1);
  localparam logic [TMR_W-1:0] TmrEnd = TMR_W'(WINDOW - 1);

  logic [9:0]       prev_q, word_q, word_d;
  logic [19:0]      win;
  tmds_dec_t        dec, dec_q;
  logic [RunW-1:0]  run_q, run_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       offset_q;
  logic             slip_q, locked_q;
  rx_state_e        state_q;
  logic             run_tok, run_valid, tmr_expire, slip;

  assign win    = {I_tmds_word, prev_q};
  assign word_d = 10'(win >> offset_q);

  tmds_word_decode u_decode (
    .word_i (word_q),
    .dec_o  (dec)
  );

  always_comb begin
    // The word right after a slip was taken at the old offset, so it never counts.
    run_tok    = ~dec.de & ~slip_q;
    run_valid  = run_tok && (run_q == RunPre);
    tmr_expire = (tmr_q == TmrEnd);
    slip       = tmr_expire & ~run_valid;
    run_d      = '0;
    if (run_tok && !slip) begin
      run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
    end
    tmr_d = (run_valid || slip) ? '0 : tmr_q + 1'b1;
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      prev_q <= '0;
      word_q <= '0;
      dec_q  <= '0;
      run_q  <= '0;
      tmr_q  <= '0;
    end else begin
      prev_q <= I_tmds_word;
      word_q <= word_d;
      dec_q  <= dec;
      run_q  <= run_d;
      tmr_q  <= tmr_d;
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= StSearch;
      locked_q <= 1'b0;
      offset_q <= '0;
      slip_q   <= 1'b0;
    end else begin
      slip_q <= slip;
      if (slip) begin
        offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      end
      unique case (state_q)
        StSearch: begin
          if (run_valid) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
        end
        StLocked: begin
          if (slip) begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_data   = locked_q ? dec_q.data : 8'h00;
  assign O_de     = locked_q & dec_q.de;
  assign O_c0     = dec_q.c0;
  assign O_c1     = dec_q.c1;
  assign O_locked = locked_q;
  assign O_offset = offset_q;
  assign O_slip   = slip_q;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: drives a serial symbol stream at chosen bit rotations and
// checks alignment, lock timing and decoded output against the transmitted symbols.
module tb_tmds_rx_channel;

  localparam int unsigned CtrlRun = 8;
  localparam int unsigned Window  = 2048;
  localparam int unsigned LineLen = 1650;
  localparam int unsigned LineTok = 370;

  typedef struct packed {
    logic       tok;
    logic [7:0] val;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tmds_word = '0;
  logic [7:0] o_data;
  logic       o_c0, o_c1, o_de, o_locked, o_slip;
  logic [3:0] o_offset;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n = 0;
  bit         bitq[$];
  sym_t       plan[$];
  sym_t       sent[$];
  int         slips[$];
  logic [3:0] offs[$];
  logic [7:0] px[4];
  int         lock_n, nslip, prev_slip;

  always #5 clk = ~clk;

  tmds_rx_channel #(
    .CTRL_RUN (CtrlRun),
    .WINDOW   (Window),
    .TMR_W    (13)
  ) dut (
    .I_pxl_clk   (clk),
    .I_rst_n     (rst_n),
    .I_tmds_word (tmds_word),
    .O_data      (o_data),
    .O_c0        (o_c0),
    .O_c1        (o_c1),
    .O_de        (o_de),
    .O_locked    (o_locked),
    .O_offset    (o_offset),
    .O_slip      (o_slip)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok_word(input logic [1:0] c);
    logic [9:0] w;
    case (c)
      2'b00:   w = 10'b1101010100;
      2'b01:   w = 10'b0010101011;
      2'b10:   w = 10'b0101010100;
      default: w = 10'b1010101011;
    endcase
    return w;
  endfunction

  function automatic bit is_tok(input logic [9:0] w);
    return (w == tok_word(2'b00)) || (w == tok_word(2'b01)) ||
           (w == tok_word(2'b10)) || (w == tok_word(2'b11));
  endfunction

  // Transmit-side encoding: m[1] inverts the low byte, m[0] picks XOR (1) or XNOR chaining.
  function automatic logic [9:0] enc_data(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = m[0] ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {m[1], m[0], m[1] ? ~qm : qm};
  endfunction

  function automatic logic [9:0] encode(input sym_t s);
    logic [9:0]  w;
    int unsigned start;
    if (s.tok) return tok_word(s.val[1:0]);
    start = $urandom_range(3, 0);
    w = enc_data(s.val, 2'(start));
    for (int k = 1; k < 4 && is_tok(w); k++) w = enc_data(s.val, 2'(start + k));
    return w;
  endfunction

  task automatic feed();
    sym_t       s;
    logic [9:0] w;
    while (bitq.size() < 10) begin
      if (plan.size() > 0) begin
        s = plan.pop_front();
      end else begin
        s.tok = 1'b0;
        s.val = 8'($urandom);
      end
      w = encode(s);
      for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
      sent.push_back(s);
    end
  endtask

  task automatic tick();
    feed();
    for (int i = 0; i < 10; i++) tmds_word[i] = bitq.pop_front();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic plan_tok(input logic [1:0] c, input int cnt);
    sym_t s;
    s.tok = 1'b1;
    s.val = {6'd0, c};
    repeat (cnt) plan.push_back(s);
  endtask

  task automatic plan_byte(input logic [7:0] b);
    sym_t s;
    s.tok = 1'b0;
    s.val = b;
    plan.push_back(s);
  endtask

  task automatic plan_data(input int cnt);
    repeat (cnt) plan_byte(8'($urandom));
  endtask

  task automatic plan_lines(input int lines);
    repeat (lines) begin
      plan_tok(2'b00, LineTok);
      plan_data(LineLen - LineTok);
    end
  endtask

  // Output after tick n carries the symbol that completed in the window two edges earlier.
  task automatic check_sym(input string tag);
    sym_t s;
    if (n >= 3) begin
      s = sent[n-3];
      chk({tag, "_de"}, o_de, !s.tok);
      if (s.tok) chk({tag, "_ctrl"}, {o_c1, o_c0}, s.val[1:0]);
      else       chk({tag, "_data"}, o_data, s.val);
    end
  endtask

  task automatic do_reset(input int rot);
    rst_n = 1'b0;
    tmds_word = '0;
    bitq.delete();
    plan.delete();
    sent.delete();
    n = 0;
    repeat (rot) bitq.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {o_data, o_c1, o_c0, o_de, o_locked, o_offset, o_slip}, 0);
    rst_n = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_outputs"}, {o_data, o_c1, o_c0, o_de, o_locked, o_slip}, 0);
    chk({tag, "_offset"}, o_offset, 0);
    @(posedge clk);
    #1;
    chk({tag, "_held"}, {o_data, o_c1, o_c0, o_de, o_locked, o_offset, o_slip}, 0);
  endtask

  initial begin
    px[0] = 8'h00; px[1] = 8'hFF; px[2] = 8'h55; px[3] = 8'hA5;

    // Aligned stream: lock timing, fixed pixel values, then the other control tokens.
    do_reset(0);
    plan_tok(2'b00, 100);
    for (int i = 0; i < 4; i++) plan_byte(px[i]);
    plan_data(20);
    for (int t = 1; t <= int'(CtrlRun) + 1; t++) tick();
    chk("t1_lock_early", o_locked, 0);
    tick();
    chk("t1_lock_edge", o_locked, 1);
    while (n < 110) begin
      tick();
      check_sym("t1");
      if (n >= 103 && n <= 106) begin
        chk("t1_px", o_data, px[n-103]);
        chk("t1_px_de", o_de, 1);
      end
    end
    plan_tok(2'b01, 10);
    plan_tok(2'b10, 10);
    plan_tok(2'b11, 10);
    plan_data(10);
    repeat (60) begin
      tick();
      check_sym("t6");
    end
    chk("t6_locked", o_locked, 1);

    // Stream rotated by 7 bits: seven slips, one window apart, then lock and clean data.
    do_reset(7);
    plan_lines(20);
    slips.delete();
    while (!o_locked && n < int'(8 * Window + 2 * LineLen)) begin
      tick();
      if (o_slip) slips.push_back(n);
    end
    chk("t2_locked", o_locked, 1);
    chk("t2_nslip", slips.size(), 7);
    prev_slip = 0;
    foreach (slips[i]) begin
      chk("t2_slip_gap", slips[i] - prev_slip, Window);
      prev_slip = slips[i];
    end
    chk("t2_offset", o_offset, 7);
    repeat (1700) begin
      tick();
      check_sym("t2");
    end
    async_reset_check("t2_rst");

    // Wrap: push the offset to 3 with token-free data, then apply a stream needing offset 2.
    do_reset(0);
    repeat (3 * Window) tick();
    chk("t3_pre_offset", o_offset, 3);
    chk("t3_pre_locked", o_locked, 0);
    plan.delete();
    repeat (2) bitq.push_back(1'b0);
    plan_lines(16);
    offs.delete();
    while (!o_locked && n < int'(16 * Window)) begin
      tick();
      if (o_slip) offs.push_back(o_offset);
    end
    chk("t3_nslip", offs.size(), 9);
    foreach (offs[i]) chk("t3_offset_seq", offs[i], (3 + i + 1) % 10);
    chk("t3_locked", o_locked, 1);
    chk("t3_offset", o_offset, 2);

    // Loss of lock: data only, expiry exactly one window after the locking run.
    lock_n = n;
    plan.delete();
    while (!o_slip && n < lock_n + int'(2 * Window)) tick();
    chk("t4_gap", n - lock_n, Window);
    chk("t4_locked", o_locked, 0);
    chk("t4_de", o_de, 0);
    chk("t4_data", o_data, 0);
    chk("t4_offset", o_offset, 3);
    tick();
    chk("t4_single_slip", o_slip, 0);

    // Valid run lands on the expiry cycle: no slip, lock kept.
    do_reset(0);
    plan_tok(2'b00, 12);
    plan_data(Window - 12);
    plan_tok(2'b00, 12);
    plan_data(50);
    nslip = 0;
    while (n < int'(CtrlRun + Window + 7)) begin
      tick();
      if (o_slip) nslip++;
    end
    chk("t5_nslip", nslip, 0);
    chk("t5_locked", o_locked, 1);
    chk("t5_offset", o_offset, 0);
    async_reset_check("t5_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
